esc_pwm_quad: RTL

- Motor-side consumer of the flight controller's four 11-bit unsigned speed commands (front/back/left/right).
- Converts each speed into a fixed-period ESC servo-style PWM pulse.
- Adds an arming sequence and a command-loss watchdog with a failsafe speed.
- Sits between the flight controller and the four ESC output pins.

---
 rtl/esc_pwm_quad.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/esc_pwm_quad.sv
// -----------------------------------------------------------------------------
// esc_pwm_quad
//
// Turns the flight controller's four 11-bit speed commands into fixed-period
// ESC servo pulses. It also provides an arming sequence and a command-loss
// watchdog that falls back to a fixed failsafe speed.
//
// Pulse width in clocks = BASE_WIDTH + 3*speed (+ trim). The period is
// 2^PERIOD_W clocks. Widths are only latched at the period wrap, so a pulse
// never changes partway through.
//
// Ports:
//   clk, rst_n                  system clock, asynchronous active-low reset
//   arm                         level: 1 requests arming, 0 disarms at once
//   spd_vld                     one-cycle strobe that captures the four speeds
//   frnt/bck/lft/rght_spd[10:0] unsigned speed commands
//   frnt/bck/lft/rght_trim[7:0] unsigned per-channel trim (only with ESC_TRIM_EN)
//   frnt/bck/lft/rght_pwm       ESC pulse outputs
//   state[1:0]                  00 DISARM, 01 ARMING, 10 ARMED, 11 FAILSAFE
//   armed                       1 in ARMED or FAILSAFE
//
// Build option: define ESC_TRIM_EN to add the trim ports.
// -----------------------------------------------------------------------------
module esc_pwm_quad #(
    parameter int          PERIOD_W     = 20,
    parameter int          BASE_WIDTH   = 50000,
    parameter int          ARM_PERIODS  = 16,
    parameter int          WDOG_PERIODS = 4,
    parameter logic [10:0] FAILSAFE_SPD = 11'h100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arm,
    input  logic        spd_vld,
    input  logic [10:0] frnt_spd,
    input  logic [10:0] bck_spd,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
`ifdef ESC_TRIM_EN
    input  logic [7:0]  frnt_trim,
    input  logic [7:0]  bck_trim,
    input  logic [7:0]  lft_trim,
    input  logic [7:0]  rght_trim,
`endif
    output logic        frnt_pwm,
    output logic        bck_pwm,
    output logic        lft_pwm,
    output logic        rght_pwm,
    output logic [1:0]  state,
    output logic        armed
);

    localparam int                ARM_W     = $clog2(ARM_PERIODS + 1);
    localparam int                WDOG_W    = $clog2(WDOG_PERIODS + 1);
    localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(ARM_PERIODS - 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(WDOG_PERIODS);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_PERIODS - 1);
    localparam logic [15:0]       BASE16    = 16'(BASE_WIDTH);

    typedef enum logic [1:0] {
        S_DISARM   = 2'b00,
        S_ARMING   = 2'b01,
        S_ARMED    = 2'b10,
        S_FAILSAFE = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] cnt;
    logic                wrap;
    logic                enable;
    logic [ARM_W-1:0]    arm_cnt;
    logic [WDOG_W-1:0]   wdog_cnt;

    // Channel order everywhere: 0 front, 1 back, 2 left, 3 right.
    logic [10:0] spd_in     [4];
    logic [7:0]  trim       [4];
    logic [10:0] hold       [4];
    logic [10:0] sel        [4];
    logic [15:0] width_calc [4];
    logic [15:0] width_act  [4];
    logic        pwm_q      [4];

    assign spd_in[0] = frnt_spd;
    assign spd_in[1] = bck_spd;
    assign spd_in[2] = lft_spd;
    assign spd_in[3] = rght_spd;

`ifdef ESC_TRIM_EN
    assign trim[0] = frnt_trim;
    assign trim[1] = bck_trim;
    assign trim[2] = lft_trim;
    assign trim[3] = rght_trim;
`else
    assign trim[0] = '0;
    assign trim[1] = '0;
    assign trim[2] = '0;
    assign trim[3] = '0;
`endif

    assign wrap     = &cnt;
    assign state    = state_q;
    assign armed    = state_q[1];
    assign frnt_pwm = pwm_q[0];
    assign bck_pwm  = pwm_q[1];
    assign lft_pwm  = pwm_q[2];
    assign rght_pwm = pwm_q[3];

    // Next state. Dropping arm wins immediately. Every other transition waits
    // for the period wrap.
    // NOTE: every always_comb output is given a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (!arm) begin
            state_d = S_DISARM;
        end else if (wrap) begin
            case (state_q)
                S_DISARM:   state_d = S_ARMING;
                S_ARMING:   if (arm_cnt == ARM_LAST) state_d = S_ARMED;
                S_ARMED:    if (!spd_vld && wdog_cnt >= WDOG_LAST) state_d = S_FAILSAFE;
                // The watchdog sits at WDOG_MAX throughout FAILSAFE. A zero
                // count means a spd_vld arrived during this period.
                S_FAILSAFE: if (spd_vld || wdog_cnt == '0) state_d = S_ARMED;
                default:    state_d = S_DISARM;
            endcase
        end
    end

    // Speed source for the width math. DISARM uses zero, so the first
    // ARMING period, which latches a width computed while still disarmed,
    // already shows the base pulse.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            case (state_q)
                S_ARMED:    sel[i] = hold[i];
                S_FAILSAFE: sel[i] = FAILSAFE_SPD;
                default:    sel[i] = '0;
            endcase
        end
    end

    // NOTE: all sequential state uses non-blocking assignments, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_DISARM;
            cnt      <= '0;
            enable   <= 1'b0;
            arm_cnt  <= '0;
            wdog_cnt <= '0;
            for (int i = 0; i < 4; i++) begin
                hold[i]       <= '0;
                width_calc[i] <= '0;
                width_act[i]  <= '0;
                pwm_q[i]      <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            cnt     <= cnt + 1'b1;

            // state_d is DISARM whenever arm is low, so this one term covers
            // both the immediate disarm and the wrap-time update.
            if (!arm || wrap) enable <= (state_d != S_DISARM);

            if (state_q == S_DISARM)          arm_cnt <= '0;
            else if (state_q == S_ARMING && wrap) arm_cnt <= arm_cnt + 1'b1;

            // A strobe coincident with a wrap counts as received.
            if (spd_vld || (state_q == S_ARMING && state_d == S_ARMED)) wdog_cnt <= '0;
            else if (wrap && wdog_cnt != WDOG_MAX)                      wdog_cnt <= wdog_cnt + 1'b1;

            for (int i = 0; i < 4; i++) begin
                if (spd_vld) hold[i] <= spd_in[i];
                // Maximum is BASE + 3*2047 + 255, which fits in 16 bits.
                width_calc[i] <= BASE16 + 16'(sel[i]) * 16'd3 + 16'(trim[i]);
                if (wrap) width_act[i] <= width_calc[i];
                // Gating with arm forces the output low on the clock that
                // observes the disarm, rather than one clock later.
                pwm_q[i] <= arm && enable && (32'(cnt) < 32'(width_act[i]));
            end
        end
    end

endmodule
